loop_mem_sequencer: RTL and testbench
=====================================

// Module: loop_mem_sequencer
// PURPOSE
//   Sequences the single-port loop/delay SRAM, one access set per audio sample.
//   On each sample tick it performs three steps: read the old sample at the circular pointer,
//   present it downstream, then optionally overwrite that location with the new sample.
//   Sits between the ADC sample path and the SRAM macro; feeds the mixer/adder path.
//   Delay length = loop_len+1 samples.
// PARAMETERS
//   ADDR_W  8   SRAM word address width (buffer depth 2**ADDR_W)
//   DATA_W  16  audio sample width, two's complement
//   RD_LAT  1   SRAM read latency in clk cycles (>=1)
// PORTS
//   clk              in   1       system clock
//   reset_n          in   1       synchronous reset, active low
//   sample_tick      in   1       1-cycle pulse: sample_in valid, start sequence
//   sample_in        in   DATA_W  new ADC sample
//   record           in   1       1: write the new sample into the buffer
//   loop             in   1       1: play back from the buffer (read)
//   delay_reverb     in   1       0: plain delay, 1: feedback write (FEEDBACK_EN only)
//   gain             in   8       feedback gain, unsigned Q0.8 (FEEDBACK_EN only)
//   loop_len         in   ADDR_W  last pointer index before wrap
//   mem_csb          out  1       SRAM chip select, active low
//   mem_web          out  1       SRAM write enable, active low
//   mem_addr         out  ADDR_W  SRAM address
//   mem_din          out  DATA_W  SRAM write data
//   mem_dout         in   DATA_W  SRAM read data
//   sample_out       out  DATA_W  delayed/looped (or bypassed) sample
//   sample_out_valid out  1       1-cycle strobe, sample_out updated
//   busy             out  1       FSM not in IDLE
//   overrun          out  1       sticky: a tick arrived while busy
// BEHAVIOUR
//   Reset (reset_n=0 at a clk edge): state=IDLE, ptr=0, mem_csb=1, mem_web=1, mem_addr=0, mem_din=0,
//     sample_out=0, sample_out_valid=0, overrun=0. Applies mid-sequence: any access is aborted,
//     with no write issued.
//   On an accepted tick, record/loop/delay_reverb/gain/loop_len/sample_in are latched and held for the sequence.
//   FSM: IDLE, BYPASS, READ, WAIT, CAPTURE, WRITE.
//     IDLE    : tick with latched loop|record = 0 -> BYPASS; otherwise -> READ.
//     BYPASS  : sample_out<=sample_in, valid=1 for this cycle; -> IDLE. No SRAM access.
//     READ    : mem_csb=0, mem_web=1, mem_addr=ptr; -> WAIT.
//     WAIT    : RD_LAT cycles, csb=1; -> CAPTURE.
//     CAPTURE : rd_q<=mem_dout; sample_out<= loop ? mem_dout : sample_in; -> WRITE.
//     WRITE   : sample_out_valid=1 for this cycle. If record: mem_csb=0, mem_web=0, mem_addr=ptr, mem_din=wdata.
//               ptr<= (ptr>=loop_len) ? 0 : ptr+1. Then -> IDLE.
//   Timing (tick in cycle T):
//     READ at T+1.
//     valid at T+3+RD_LAT.
//     IDLE at T+4+RD_LAT, and a tick in that cycle is accepted.
//     Bypass: valid at T+1.
//   mem_csb=1 and mem_web=1 in every state except READ and WRITE(record).
//   Write data: wdata=sample_in (plain delay).
//   Pointer wrap: ptr==loop_len -> 0. If loop_len is shrunk below ptr, the next advance -> 0.
//     loop_len=0 gives a 1-sample delay.
//   Tick while busy: tick is dropped, overrun<=1, and the sequence in progress is unaffected.
//     overrun stays set until reset.
//   Mode change between ticks takes effect at the next accepted tick only.
//   Neither record nor loop: the pointer does not advance.
// CONFIGURATION
//   LOOP_MEM_FEEDBACK_EN defined:
//     When latched delay_reverb=1 and record=1:
//       wdata = sat(sample_in + ((rd_q * gain) >>> 8)).
//       The product is signed, DATA_W+9 bits; the result saturates to the DATA_W signed range
//       (+32767/-32768 at 16 b).
//     delay_reverb=0 behaves as plain delay.
//   Not defined: wdata=sample_in always; gain and delay_reverb are ignored (unconnected internally).
// TESTING
//   1. Reset then idle:
//      all outputs at reset values, mem_csb=1 throughout 20 cycles, busy=0.
//   2. Bypass: record=0, loop=0, tick with sample_in=16'h1234
//      -> next cycle sample_out=16'h1234, valid 1 cycle, mem_csb never 0.
//   3. Delay: record=1, loop=1, loop_len=3, ticks with 1,2,3,4,5,6 (every 8 cycles; memory pre-zeroed)
//      -> outputs 0,0,0,0,1,2; addresses 0,1,2,3,0,1; valid at T+4.
//   4. Overrun: tick, then tick 2 cycles later
//      -> second tick ignored, overrun=1 and sticky, only one valid pulse.
//      Then reset -> overrun=0.
//   5. Mid-op reset: reset_n=0 in the WAIT cycle
//      -> no write strobe (mem_web stays 1), ptr=0 next tick.
//   6. FEEDBACK_EN: gain=8'h80, delay_reverb=1, loop_len=0, stored 16'h7000, sample_in=16'h4000
//      -> mem_din=16'h7800.
//      With stored 16'h7FFF, sample_in 16'h7FFF -> mem_din=16'h7FFF (saturated).

Source files
------------

// File: rtl/loop_mem_sequencer_if.sv
// rtl/loop_mem_sequencer_if.sv - single-port SRAM bus between the loop sequencer and the SRAM macro
//
// Purpose : groups the loop/delay SRAM macro pins so the sequencer and the
//           macro (or a bench model of it) connect through one port.
// Signals : mem_csb  - chip select, active low   (master -> slave)
//           mem_web  - write enable, active low  (master -> slave)
//           mem_addr - word address              (master -> slave)
//           mem_din  - write data                (master -> slave)
//           mem_dout - read data                 (slave -> master)
// Modports: master = sequencer side, slave = SRAM side.

interface loop_mem_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              mem_csb;
    logic              mem_web;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output mem_csb,
        output mem_web,
        output mem_addr,
        output mem_din,
        input  mem_dout
    );

    modport slave (
        input  mem_csb,
        input  mem_web,
        input  mem_addr,
        input  mem_din,
        output mem_dout
    );
endinterface

// File: rtl/loop_mem_sequencer.sv
// rtl/loop_mem_sequencer.sv - per-sample read/present/write sequencer for the loop/delay SRAM
//
// Purpose : on every accepted sample tick, reads the old sample at the circular
//           pointer, presents it downstream (or the new sample when not looping),
//           then optionally overwrites that word with the new sample. Delay
//           length is loop_len+1 samples. With neither record nor loop set the
//           sample is bypassed with no SRAM access.
// Build   : define LOOP_MEM_FEEDBACK_EN to enable the reverb feedback write
//           (wdata = sat(sample_in + ((old * gain) >>> 8)) when delay_reverb=1).
//           Without it, gain and delay_reverb are ignored.
// Ports   : clk, reset_n (sync, active low)
//           sample_tick, sample_in, record, loop, delay_reverb, gain, loop_len
//             - sample strobe, new sample and mode controls (latched on accept)
//           mem (loop_mem_sequencer_if.master) - SRAM bus
//           sample_out, sample_out_valid - output sample and 1-cycle strobe
//           busy    - sequence in progress
//           overrun - sticky, a tick arrived while busy

module loop_mem_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic [DATA_W-1:0]    sample_in,
    input  logic                 record,
    input  logic                 loop,
    input  logic                 delay_reverb,
    input  logic [7:0]           gain,
    input  logic [ADDR_W-1:0]    loop_len,
    loop_mem_sequencer_if.master mem,
    output logic [DATA_W-1:0]    sample_out,
    output logic                 sample_out_valid,
    output logic                 busy,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYPASS,
        S_READ,
        S_WAIT,
        S_CAPTURE,
        S_WRITE
    } state_t;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;

    // Controls latched on an accepted tick and held for the whole sequence.
    logic              rec_q, rec_d;
    logic              loop_q, loop_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [DATA_W-1:0] sin_q, sin_d;

    // Registered outputs.
    logic              csb_q, csb_d;
    logic              web_q, web_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] sout_q, sout_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    // Data to write back; evaluated during CAPTURE while mem_dout holds the
    // old sample, so the write can be issued on the following cycle.
    logic [DATA_W-1:0] wdata;

`ifdef LOOP_MEM_FEEDBACK_EN
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic              dr_q, dr_d;
    logic [7:0]        gain_q, gain_d;
    logic signed [DATA_W+8:0] prod;
    logic signed [DATA_W:0]   fb_term;
    logic signed [DATA_W+1:0] fb_sum;
    logic [7:0]        unused_prod_lsb;

    always_comb begin
        // Gain is unsigned Q0.8: zero-extend to 9 bits so the multiply stays signed.
        prod    = $signed(mem.mem_dout) * $signed({1'b0, gain_q});
        fb_term = prod[DATA_W+8:8];
        fb_sum  = {{2{sin_q[DATA_W-1]}}, sin_q} + {fb_term[DATA_W], fb_term};
        if (!(dr_q && rec_q)) begin
            wdata = sin_q;
        end else if (fb_sum[DATA_W+1:DATA_W-1] == 3'b000 ||
                     fb_sum[DATA_W+1:DATA_W-1] == 3'b111) begin
            wdata = fb_sum[DATA_W-1:0];
        end else begin
            wdata = fb_sum[DATA_W+1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign unused_prod_lsb = prod[7:0];

    always_comb begin
        dr_d   = dr_q;
        gain_d = gain_q;
        if (state_q == S_IDLE && sample_tick) begin
            dr_d   = delay_reverb;
            gain_d = gain;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dr_q   <= 1'b0;
            gain_q <= 8'd0;
        end else begin
            dr_q   <= dr_d;
            gain_q <= gain_d;
        end
    end
`else
    logic unused_fb;

    assign wdata     = sin_q;
    assign unused_fb = ^{gain, delay_reverb};
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        rec_d   = rec_q;
        loop_d  = loop_q;
        len_d   = len_q;
        sin_d   = sin_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        sout_d  = sout_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            S_IDLE: begin
                if (sample_tick) begin
                    rec_d  = record;
                    loop_d = loop;
                    len_d  = loop_len;
                    sin_d  = sample_in;
                    if (!(loop || record)) begin
                        state_d = S_BYPASS;
                        sout_d  = sample_in;
                        valid_d = 1'b1;
                    end else begin
                        // Read strobe is issued as we enter READ.
                        state_d = S_READ;
                        csb_d   = 1'b0;
                        addr_d  = ptr_q;
                    end
                end
            end
            S_BYPASS: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_CAPTURE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                // Valid strobe and optional write strobe both land in WRITE.
                state_d = S_WRITE;
                sout_d  = loop_q ? mem.mem_dout : sin_q;
                valid_d = 1'b1;
                if (rec_q) begin
                    csb_d  = 1'b0;
                    web_d  = 1'b0;
                    addr_d = ptr_q;
                    din_d  = wdata;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                // >= also catches loop_len shrunk below the current pointer.
                ptr_d   = (ptr_q >= len_q) ? '0 : ptr_q + 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample_tick && state_q != S_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            rec_q   <= 1'b0;
            loop_q  <= 1'b0;
            len_q   <= '0;
            sin_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            sout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            rec_q   <= rec_d;
            loop_q  <= loop_d;
            len_q   <= len_d;
            sin_q   <= sin_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign mem.mem_csb       = csb_q;
    assign mem.mem_web       = web_q;
    assign mem.mem_addr      = addr_q;
    assign mem.mem_din       = din_q;
    assign sample_out        = sout_q;
    assign sample_out_valid  = valid_q;
    assign busy              = (state_q != S_IDLE);
    assign overrun           = ovr_q;

endmodule

// File: tb/tb_loop_mem_sequencer.sv
// tb/tb_loop_mem_sequencer.sv - self-checking bench for loop_mem_sequencer

module tb_loop_mem_sequencer;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;
    localparam int MAXC   = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [15:0] sample_in = 16'h0;
    logic        record = 1'b0;
    logic        loop = 1'b0;
    logic        delay_reverb = 1'b0;
    logic [7:0]  gain = 8'h0;
    logic [7:0]  loop_len = 8'h0;
    logic [15:0] sample_out;
    logic        sample_out_valid;
    logic        busy;
    logic        overrun;

    loop_mem_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    loop_mem_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sample_tick      (sample_tick),
        .sample_in        (sample_in),
        .record           (record),
        .loop             (loop),
        .delay_reverb     (delay_reverb),
        .gain             (gain),
        .loop_len         (loop_len),
        .mem              (mem_if),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    // SRAM macro model, read latency 1, pre-zeroed.
    logic [15:0] sram [256] = '{default: 16'h0};
    always @(posedge clk) begin
        if (!mem_if.mem_csb) begin
            if (!mem_if.mem_web) sram[mem_if.mem_addr] <= mem_if.mem_din;
            else                 mem_if.mem_dout <= sram[mem_if.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Expected per-cycle schedule built from the timing rules at tick time.
    logic        exp_csb   [MAXC];
    logic        exp_web   [MAXC];
    logic        exp_valid [MAXC];
    logic        exp_busy  [MAXC];
    logic        exp_ov    [MAXC];
    logic [7:0]  exp_addr  [MAXC];
    logic [15:0] exp_din   [MAXC];
    logic [15:0] exp_out   [MAXC];

    logic [15:0] ref_mem [256];
    int          m_ptr;
    int          busy_until;
    int          pend_cycle;
    int          pend_addr;
    logic [15:0] pend_old;

`ifdef LOOP_MEM_FEEDBACK_EN
    function automatic logic [15:0] fb_val(input logic [15:0] s, input logic [15:0] rd, input logic [7:0] g);
        int sum;
        sum = int'($signed(s)) + ((int'($signed(rd)) * int'(g)) >>> 8);
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        return sum[15:0];
    endfunction
`endif

    task automatic m_tick(input int t);
        logic [15:0] wd;
        if (t < busy_until) begin
            for (int c = t + 1; c < MAXC; c++) exp_ov[c] = 1'b1;
            return;
        end
        if (!record && !loop) begin
            exp_valid[t+1] = 1'b1;
            exp_out[t+1]   = sample_in;
            exp_busy[t+1]  = 1'b1;
            busy_until     = t + 2;
            return;
        end
        for (int c = t + 1; c <= t + 3 + RD_LAT; c++) exp_busy[c] = 1'b1;
        exp_csb[t+1]  = 1'b0;
        exp_web[t+1]  = 1'b1;
        exp_addr[t+1] = m_ptr[7:0];
        exp_valid[t+3+RD_LAT] = 1'b1;
        exp_out[t+3+RD_LAT]   = loop ? ref_mem[m_ptr] : sample_in;
        if (record) begin
            wd = sample_in;
`ifdef LOOP_MEM_FEEDBACK_EN
            if (delay_reverb) wd = fb_val(sample_in, ref_mem[m_ptr], gain);
`endif
            exp_csb[t+3+RD_LAT]  = 1'b0;
            exp_web[t+3+RD_LAT]  = 1'b0;
            exp_addr[t+3+RD_LAT] = m_ptr[7:0];
            exp_din[t+3+RD_LAT]  = wd;
            pend_cycle = t + 3 + RD_LAT;
            pend_addr  = m_ptr;
            pend_old   = ref_mem[m_ptr];
            ref_mem[m_ptr] = wd;
        end
        m_ptr = (m_ptr >= int'(loop_len)) ? 0 : m_ptr + 1;
        busy_until = t + 4 + RD_LAT;
    endtask

    task automatic m_reset(input int r);
        for (int c = r + 1; c < MAXC; c++) begin
            exp_csb[c] = 1'b1; exp_web[c] = 1'b1; exp_valid[c] = 1'b0;
            exp_busy[c] = 1'b0; exp_ov[c] = 1'b0;
        end
        if (pend_cycle > r) ref_mem[pend_addr] = pend_old;
        pend_cycle = -1;
        m_ptr      = 0;
        busy_until = 0;
    endtask

    // Observed traffic, used by the literal checks.
    int          rd_addrs[$];
    logic [15:0] wr_data[$];
    logic [15:0] outs[$];
    logic        run_cmp = 1'b0;

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("mem_csb", mem_if.mem_csb, exp_csb[cyc]);
            if (!exp_csb[cyc]) begin
                chk("mem_web", mem_if.mem_web, exp_web[cyc]);
                chk("mem_addr", mem_if.mem_addr, exp_addr[cyc]);
                if (!exp_web[cyc]) chk("mem_din", mem_if.mem_din, exp_din[cyc]);
            end
            chk("sample_out_valid", sample_out_valid, exp_valid[cyc]);
            if (exp_valid[cyc]) chk("sample_out", sample_out, exp_out[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("overrun", overrun, exp_ov[cyc]);
            if (mem_if.mem_csb === 1'b0 && mem_if.mem_web === 1'b1) rd_addrs.push_back(int'(mem_if.mem_addr));
            if (mem_if.mem_csb === 1'b0 && mem_if.mem_web === 1'b0) wr_data.push_back(mem_if.mem_din);
            if (sample_out_valid === 1'b1) outs.push_back(sample_out);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs are scrambled right after the tick to show only latched values matter.
    task automatic do_tick(input logic [15:0] s, input logic r, input logic l,
                           input logic dr, input logic [7:0] g, input logic [7:0] len);
        sample_in = s; record = r; loop = l; delay_reverb = dr; gain = g; loop_len = len;
        sample_tick = 1'b1;
        m_tick(cyc);
        step(1);
        sample_tick = 1'b0;
        sample_in = 16'hBEEF; record = ~r; loop = ~l; loop_len = 8'hFF; gain = 8'h5A;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        m_reset(cyc);
        step(n);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, lat, n0, n1;
        logic [15:0] saved;
        static logic [15:0] exp_outs [6]  = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
        static int          exp_addrs [6] = '{0, 1, 2, 3, 0, 1};

        for (int c = 0; c < MAXC; c++) begin
            exp_csb[c] = 1'b1; exp_web[c] = 1'b1; exp_valid[c] = 1'b0;
            exp_busy[c] = 1'b0; exp_ov[c] = 1'b0;
            exp_addr[c] = 8'h0; exp_din[c] = 16'h0; exp_out[c] = 16'h0;
        end
        foreach (ref_mem[i]) ref_mem[i] = 16'h0;
        m_ptr = 0; busy_until = 0; pend_cycle = -1;

        // 1. reset then idle
        step(1);
        run_cmp = 1'b1;
        step(3);
        reset_n = 1'b1;
        step(1);
        chk("rst_mem_csb", mem_if.mem_csb, 1'b1);
        chk("rst_mem_web", mem_if.mem_web, 1'b1);
        chk("rst_mem_addr", mem_if.mem_addr, 8'h0);
        chk("rst_mem_din", mem_if.mem_din, 16'h0);
        chk("rst_sample_out", sample_out, 16'h0);
        chk("rst_valid", sample_out_valid, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_busy", busy, 1'b0);
        step(20);

        // 2. bypass
        do_tick(16'h1234, 1'b0, 1'b0, 1'b0, 8'h00, 8'd3);
        chk("bypass_out", sample_out, 16'h1234);
        chk("bypass_valid", sample_out_valid, 1'b1);
        step(1);
        chk("bypass_valid_drop", sample_out_valid, 1'b0);
        step(4);

        // 3. plain delay, loop_len=3
        n0 = outs.size();
        n1 = rd_addrs.size();
        t0 = cyc;
        do_tick(16'd1, 1'b1, 1'b1, 1'b0, 8'h00, 8'd3);
        lat = -1;
        for (int i = 0; i < 7; i++) begin
            if (sample_out_valid && lat < 0) lat = cyc - t0;
            step(1);
        end
        chk("valid_latency", lat, 3 + RD_LAT);
        for (int k = 2; k <= 6; k++) begin
            do_tick(16'(k), 1'b1, 1'b1, 1'b0, 8'h00, 8'd3);
            step(7);
        end
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("delay_out%0d", k), outs[n0+k], exp_outs[k]);
            chk($sformatf("delay_addr%0d", k), rd_addrs[n1+k], exp_addrs[k]);
        end

        // Other modes: loop only, record only, shrunk loop_len, ignored feedback controls
        do_tick(16'h0AAA, 1'b0, 1'b1, 1'b0, 8'h00, 8'd3);
        step(7);
        do_tick(16'h0BBB, 1'b1, 1'b0, 1'b0, 8'h00, 8'd3);
        step(7);
        do_tick(16'h0CCC, 1'b1, 1'b1, 1'b0, 8'h00, 8'd1);
        step(7);
        do_tick(16'h0100, 1'b1, 1'b1, 1'b1, 8'hFF, 8'd3);
        step(7);
        do_tick(16'h0DDD, 1'b0, 1'b1, 1'b0, 8'h00, 8'd3);
        step(7);

        // 4. overrun
        n0 = outs.size();
        do_tick(16'h0777, 1'b1, 1'b1, 1'b0, 8'h00, 8'd3);
        step(1);
        do_tick(16'h0888, 1'b1, 1'b1, 1'b0, 8'h00, 8'd3);
        step(6);
        chk("overrun_set", overrun, 1'b1);
        chk("overrun_one_valid", outs.size() - n0, 1);
        step(10);
        chk("overrun_sticky", overrun, 1'b1);
        do_reset(2);
        step(1);
        chk("overrun_cleared", overrun, 1'b0);

        // 5. reset during WAIT
        do_tick(16'd100, 1'b1, 1'b1, 1'b0, 8'h00, 8'd5);
        step(7);
        do_tick(16'd200, 1'b1, 1'b1, 1'b0, 8'h00, 8'd5);
        step(7);
        saved = ref_mem[2];
        do_tick(16'd300, 1'b1, 1'b1, 1'b0, 8'h00, 8'd5);
        step(1);
        do_reset(2);
        step(3);
        chk("abort_no_write", sram[2], saved);
        n1 = rd_addrs.size();
        do_tick(16'd400, 1'b1, 1'b1, 1'b0, 8'h00, 8'd5);
        step(7);
        chk("abort_ptr_zero", rd_addrs[n1], 0);

`ifdef LOOP_MEM_FEEDBACK_EN
        // 6. feedback write
        do_reset(2);
        step(2);
        do_tick(16'h7000, 1'b1, 1'b1, 1'b0, 8'h80, 8'd0);
        step(7);
        n0 = wr_data.size();
        do_tick(16'h4000, 1'b1, 1'b1, 1'b1, 8'h80, 8'd0);
        step(7);
        chk("fb_din", wr_data[n0], 16'h7800);
        do_tick(16'h7FFF, 1'b1, 1'b1, 1'b0, 8'h80, 8'd0);
        step(7);
        n0 = wr_data.size();
        do_tick(16'h7FFF, 1'b1, 1'b1, 1'b1, 8'h80, 8'd0);
        step(7);
        chk("fb_din_sat", wr_data[n0], 16'h7FFF);
`endif

        step(2);
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
